axis_out_requant: RTL and testbench
===================================

AXIS_OUT_REQUANT -- requirements
Module: axis_out_requant

Interface
REQ-001 The block SHALL have parameter ROWS, default `ROWS, the number of words per beat.
REQ-002 The block SHALL have parameter WORD_WIDTH_IN, default `WORD_WIDTH_ACC, the signed accumulator word width.
REQ-003 The block SHALL have parameter WORD_WIDTH_OUT, default 8, the signed output word width.
REQ-004 The block SHALL have parameter TUSER_WIDTH, default `TUSER_WIDTH_CONV_OUT, the sideband width, passed through untouched.
REQ-005 aclk  in  1  clock; all logic SHALL be rising-edge.
REQ-006 aresetn  in  1  reset, asynchronous, active-low.
REQ-007 s_valid/s_ready/s_last  in/out/in  1 each  upstream AXIS handshake, driven by the shift-out stage.
REQ-008 s_data  in  ROWS*WORD_WIDTH_IN  signed accumulators, row r at slice r.
REQ-009 s_user  in  TUSER_WIDTH  sideband.
REQ-010 m_valid/m_ready/m_last  out/in/out  1 each  downstream AXIS handshake.
REQ-011 m_data  out  ROWS*WORD_WIDTH_OUT  requantized words.
REQ-012 m_user  out  TUSER_WIDTH  delayed s_user.
REQ-013 cfg_wr_en/cfg_wr_addr/cfg_wr_data  in  1/clog2(ROWS)/WORD_WIDTH_IN  per-row bias write port.
REQ-014 cfg_shift/cfg_relu  in  5/1  right-shift amount and ReLU enable.
REQ-015 cfg_ready  out  1  high when bias writes are accepted.
REQ-016 sat_count  out  16  saturation-event counter.

Function
REQ-017 The block SHALL be a 3-stage elastic pipeline: S1 bias add, S2 round-shift, S3 ReLU+saturate, with one valid bit per stage.
REQ-018 A stage SHALL load when its successor is empty or advancing; s_ready = !v1 || S1 advancing; latency 3 cycles with m_ready high.
REQ-019 Throughput SHALL be one beat per cycle under continuous m_ready, with no bubbles and no beat loss or duplication under any m_ready pattern.
REQ-020 S1 SHALL compute s_data[r] + bias[r] at WORD_WIDTH_IN+1 bits, sign-extended.
REQ-021 S2 SHALL compute (x + 2^(sh-1)) >>> sh when sh>0 and x otherwise, at WORD_WIDTH_IN+2 bits.
REQ-022 S3 SHALL clamp to [-2^(WORD_WIDTH_OUT-1), 2^(WORD_WIDTH_OUT-1)-1]; if relu=1 the lower bound SHALL be 0 instead.
REQ-023 cfg_shift and cfg_relu SHALL be latched on the first accepted beat of a packet (first beat after reset or after an accepted s_last) and held for the whole packet.
REQ-024 busy SHALL be set on the first accepted beat and cleared when the beat with m_last is accepted downstream; cfg_ready = !busy.
REQ-025 A bias write with cfg_ready=1 SHALL update bias[cfg_wr_addr] at the next edge; a write with cfg_ready=0 SHALL be ignored; a write coinciding with the first beat of a packet SHALL be ignored.
REQ-026 A write with cfg_wr_addr >= ROWS SHALL be ignored.
REQ-027 s_last and s_user SHALL travel with their beat through all stages.
REQ-028 sat_count SHALL increment by 1 per output beat in which any row clipped, counted when the beat is accepted downstream.
REQ-029 A clip caused only by ReLU zeroing SHALL NOT be counted.
REQ-030 sat_count SHALL saturate at 0xFFFF.

Reset
REQ-031 On aresetn low the block SHALL clear all stage valids, busy, and sat_count.
REQ-032 On aresetn low all bias entries SHALL be set to 0 and the latched shift and relu to 0.
REQ-033 During and after reset s_ready=1, m_valid=0, m_last=0, and cfg_ready=1.
REQ-034 A reset mid-packet SHALL drop every in-flight beat without emitting it.

Structure
REQ-035 The requant config struct (shift, relu) and the saturation bounds SHALL live in the shared package.
REQ-036 The per-row arithmetic SHALL be one sub-module, requant_lane, instantiated ROWS times.
REQ-037 Valid/ready control and sat_count SHALL live in the top level.

Verification
REQ-038 Test 1 (basic): bias[0]=10, shift=2, relu=0, s_data[0]=21 -> m_data[0]=8 ((31+2)>>2), 3 cycles after acceptance.
REQ-039 Test 2 (clipping): s_data[0]=-1000, relu=0 -> m_data[0]=-128 and sat_count 0->1; the same input with relu=1 -> m_data[0]=0 and sat_count unchanged.
REQ-040 Test 3 (backpressure): 20 beats carrying s_data=i, bias 0, shift 0, random m_ready at 50% -> outputs 0..19 in order, with m_last on beat 19 only.
REQ-041 Test 4 (config guard): a bias write issued mid-packet is ignored and cfg_ready=0; the same write issued after m_last is accepted takes effect on the next packet.
REQ-042 Test 5 (reset): aresetn pulsed with 2 beats in flight -> no m_valid afterwards, sat_count=0, bias=0.
REQ-043 Test 6 (counter limit): force 65536+ clipped beats -> sat_count holds at 0xFFFF.

Source files
------------

// File: rtl/axis_out_requant_pkg.sv
// Shared requantizer types: per-packet config (shift, relu) and signed saturation bounds.
`ifndef ROWS
`define ROWS 4
`endif
`ifndef WORD_WIDTH_ACC
`define WORD_WIDTH_ACC 32
`endif
`ifndef TUSER_WIDTH_CONV_OUT
`define TUSER_WIDTH_CONV_OUT 4
`endif

package axis_out_requant_pkg;

   localparam int SHIFT_W = 5;
   localparam int SAT_W   = 16;

   typedef struct packed {
      logic [SHIFT_W-1:0] shift;
      logic               relu;
   } rq_cfg_t;

   function automatic longint sat_hi(input int w);
      return (longint'(1) << (w - 1)) - 1;
   endfunction

   function automatic longint sat_lo(input int w);
      return -(longint'(1) << (w - 1));
   endfunction

endpackage

// File: rtl/axis_out_requant_lane.sv
// One row of the requant datapath: bias add, round-shift, ReLU+clamp; 3 register stages.
// Stage enables come from the top-level handshake so every lane advances in lockstep.
module requant_lane
   import axis_out_requant_pkg::*;
#(
   parameter int WI = 32,
   parameter int WO = 8
) (
   input  logic                 aclk,
   input  logic                 aresetn,
   input  logic                 i_ld1,
   input  logic                 i_ld2,
   input  logic                 i_ld3,
   input  logic signed [WI-1:0] i_data,
   input  logic signed [WI-1:0] i_bias,
   input  logic [SHIFT_W-1:0]   i_shift,
   input  logic                 i_relu,
   output logic signed [WO-1:0] o_data,
   output logic                 o_clip
);

   localparam logic signed [WI+1:0] HI = (WI+2)'(sat_hi(WO));
   localparam logic signed [WI+1:0] LO = (WI+2)'(sat_lo(WO));

   logic signed [WI:0]   r_x1;
   logic signed [WI+1:0] r_x2;
   logic signed [WO-1:0] r_y3;
   logic                 r_clip3;

   logic signed [WI+1:0] w_x1e, w_rnd, w_x2, w_lo;
   logic signed [WO-1:0] w_y;
   logic                 w_clip;

   always_comb begin
      w_x1e = {r_x1[WI], r_x1};
      w_rnd = '0;
      w_x2  = w_x1e;
      if (i_shift != '0) begin
         w_rnd = (WI+2)'(1) << (i_shift - 5'd1);
         w_x2  = (w_x1e + w_rnd) >>> i_shift;
      end
   end

   // A value pushed below the bound only by ReLU is not reported as a clip.
   always_comb begin
      w_lo   = i_relu ? '0 : LO;
      w_y    = r_x2[WO-1:0];
      w_clip = 1'b0;
      if (r_x2 > HI) begin
         w_y    = HI[WO-1:0];
         w_clip = 1'b1;
      end else if (r_x2 < w_lo) begin
         w_y    = w_lo[WO-1:0];
         w_clip = !i_relu;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_x1    <= '0;
         r_x2    <= '0;
         r_y3    <= '0;
         r_clip3 <= 1'b0;
      end else begin
         if (i_ld1) r_x1 <= {i_data[WI-1], i_data} + {i_bias[WI-1], i_bias};
         if (i_ld2) r_x2 <= w_x2;
         if (i_ld3) begin
            r_y3    <= w_y;
            r_clip3 <= w_clip;
         end
      end
   end

   assign o_data = r_y3;
   assign o_clip = r_clip3;

endmodule

// File: rtl/axis_out_requant.sv
// AXIS output requantizer: per-row bias, rounding shift, ReLU/saturate; 3-cycle latency.
// Elastic 3-stage pipeline, full rate; s_ready falls only when S1 is full and cannot advance.
module axis_out_requant
   import axis_out_requant_pkg::*;
#(
   parameter int ROWS           = `ROWS,
   parameter int WORD_WIDTH_IN  = `WORD_WIDTH_ACC,
   parameter int WORD_WIDTH_OUT = 8,
   parameter int TUSER_WIDTH    = `TUSER_WIDTH_CONV_OUT,
   parameter int AW             = (ROWS > 1) ? $clog2(ROWS) : 1
) (
   input  logic                           aclk,
   input  logic                           aresetn,
   input  logic                           s_valid,
   output logic                           s_ready,
   input  logic                           s_last,
   input  logic [ROWS*WORD_WIDTH_IN-1:0]  s_data,
   input  logic [TUSER_WIDTH-1:0]         s_user,
   output logic                           m_valid,
   input  logic                           m_ready,
   output logic                           m_last,
   output logic [ROWS*WORD_WIDTH_OUT-1:0] m_data,
   output logic [TUSER_WIDTH-1:0]         m_user,
   input  logic                           cfg_wr_en,
   input  logic [AW-1:0]                  cfg_wr_addr,
   input  logic [WORD_WIDTH_IN-1:0]       cfg_wr_data,
   input  logic [SHIFT_W-1:0]             cfg_shift,
   input  logic                           cfg_relu,
   output logic                           cfg_ready,
   output logic [SAT_W-1:0]               sat_count
);

   localparam int WI = WORD_WIDTH_IN;
   localparam int WO = WORD_WIDTH_OUT;

   logic                   r_v1, r_v2, r_v3;
   logic                   r_last1, r_last2, r_last3;
   logic [TUSER_WIDTH-1:0] r_user1, r_user2, r_user3;
   rq_cfg_t                r_cfg, r_cfg1;
   logic                   r_relu2;
   logic                   r_first, r_busy;
   logic [SAT_W-1:0]       r_sat;
   logic [WI-1:0]          r_bias [ROWS];

   logic                   w_ld1, w_ld2, w_ld3, w_out, w_wr;
   logic [ROWS-1:0]        w_clip;
   rq_cfg_t                w_cfg_in;

   assign w_ld3   = r_v2 && (!r_v3 || m_ready);
   assign w_ld2   = r_v1 && (!r_v2 || w_ld3);
   assign s_ready = !r_v1 || w_ld2;
   assign w_ld1   = s_valid && s_ready;
   assign w_out   = r_v3 && m_ready;
   assign w_wr    = cfg_wr_en && !r_busy && !(w_ld1 && r_first) && (32'(cfg_wr_addr) < ROWS);

   // Config rides with each beat so a following packet cannot disturb beats still in flight.
   always_comb begin
      w_cfg_in = r_cfg;
      if (r_first) w_cfg_in = '{shift: cfg_shift, relu: cfg_relu};
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_v1 <= 1'b0;  r_v2 <= 1'b0;  r_v3 <= 1'b0;
         r_last1 <= 1'b0;  r_last2 <= 1'b0;  r_last3 <= 1'b0;
         r_user1 <= '0;  r_user2 <= '0;  r_user3 <= '0;
         r_cfg <= '0;  r_cfg1 <= '0;  r_relu2 <= 1'b0;
         r_first <= 1'b1;
         r_busy  <= 1'b0;
         r_sat   <= '0;
         for (int r = 0; r < ROWS; r++) r_bias[r] <= '0;
      end else begin
         if (w_ld1)      r_v1 <= 1'b1;
         else if (w_ld2) r_v1 <= 1'b0;
         if (w_ld2)      r_v2 <= 1'b1;
         else if (w_ld3) r_v2 <= 1'b0;
         if (w_ld3)      r_v3 <= 1'b1;
         else if (w_out) r_v3 <= 1'b0;

         if (w_ld1) begin
            r_last1 <= s_last;
            r_user1 <= s_user;
            r_cfg1  <= w_cfg_in;
            r_first <= s_last;
         end
         if (w_ld2) begin
            r_last2 <= r_last1;
            r_user2 <= r_user1;
            r_relu2 <= r_cfg1.relu;
         end
         if (w_ld3) begin
            r_last3 <= r_last2;
            r_user3 <= r_user2;
         end

         if (w_ld1 && r_first)     r_cfg  <= w_cfg_in;
         if (w_ld1 && r_first)     r_busy <= 1'b1;
         else if (w_out && r_last3) r_busy <= 1'b0;

         if (w_out && (|w_clip) && (r_sat != '1)) r_sat <= r_sat + 1'b1;
         if (w_wr) r_bias[cfg_wr_addr] <= cfg_wr_data;
      end
   end

   for (genvar g = 0; g < ROWS; g++) begin : g_lane
      requant_lane #(.WI(WI), .WO(WO)) u_lane (
         .aclk    (aclk),
         .aresetn (aresetn),
         .i_ld1   (w_ld1),
         .i_ld2   (w_ld2),
         .i_ld3   (w_ld3),
         .i_data  (s_data[g*WI +: WI]),
         .i_bias  (r_bias[g]),
         .i_shift (r_cfg1.shift),
         .i_relu  (r_relu2),
         .o_data  (m_data[g*WO +: WO]),
         .o_clip  (w_clip[g])
      );
   end

   assign m_valid   = r_v3;
   assign m_last    = r_v3 && r_last3;
   assign m_user    = r_user3;
   assign cfg_ready = !r_busy;
   assign sat_count = r_sat;

endmodule

// File: tb/tb_axis_out_requant.sv
// Bench for axis_out_requant: directed steps plus randomized packets against an arithmetic model.
module tb_axis_out_requant;

   localparam int ROWS = 4, WI = 32, WO = 8, TU = 4;
   localparam int AW = $clog2(ROWS);

   logic                 aclk = 1'b0, aresetn = 1'b0;
   logic                 s_valid = 1'b0, s_ready, s_last = 1'b0;
   logic [ROWS*WI-1:0]   s_data = '0;
   logic [TU-1:0]        s_user = '0;
   logic                 m_valid, m_ready = 1'b1, m_last;
   logic [ROWS*WO-1:0]   m_data;
   logic [TU-1:0]        m_user;
   logic                 cfg_wr_en = 1'b0;
   logic [AW-1:0]        cfg_wr_addr = '0;
   logic [WI-1:0]        cfg_wr_data = '0;
   logic [4:0]           cfg_shift = '0;
   logic                 cfg_relu = 1'b0;
   logic                 cfg_ready;
   logic [15:0]          sat_count;

   always #5 aclk = ~aclk;

   axis_out_requant #(.ROWS(ROWS), .WORD_WIDTH_IN(WI), .WORD_WIDTH_OUT(WO), .TUSER_WIDTH(TU)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last), .s_data(s_data), .s_user(s_user),
      .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .m_data(m_data), .m_user(m_user),
      .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
      .cfg_shift(cfg_shift), .cfg_relu(cfg_relu), .cfg_ready(cfg_ready), .sat_count(sat_count)
   );

   typedef struct {
      logic [ROWS*WO-1:0] dat;
      logic               last;
      logic [TU-1:0]      user;
      bit                 clip;
      int                 cyc;
   } exp_t;

   exp_t               q[$];
   longint             bias_m [ROWS];
   int                 m_sh, m_sat, cyc, n_vec, n_err, rdy_pct, last_lat, ncy;
   bit                 m_relu, m_first, m_busy;
   logic [ROWS*WO-1:0] last_out;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   task automatic model(input logic [ROWS*WI-1:0] d, output logic [ROWS*WO-1:0] o, output bit clip);
      longint x, hi, lo;
      hi   = (longint'(1) << (WO - 1)) - 1;
      lo   = m_relu ? 0 : -(longint'(1) << (WO - 1));
      clip = 0;
      o    = '0;
      for (int r = 0; r < ROWS; r++) begin
         x = longint'($signed(d[r*WI +: WI])) + bias_m[r];
         if (m_sh > 0) x = (x + (longint'(1) << (m_sh - 1))) >>> m_sh;
         if (x > hi) begin
            x = hi; clip = 1;
         end else if (x < lo) begin
            x = lo; if (!m_relu) clip = 1;
         end
         o[r*WO +: WO] = x[WO-1:0];
      end
   endtask

   task automatic step(output bit acc);
      bit in_acc, out_acc, was_first, c;
      exp_t e;
      logic [ROWS*WO-1:0] o;
      @(negedge aclk);
      chk("cfg_ready", cfg_ready, !m_busy);
      chk("sat_count", sat_count, m_sat);
      in_acc    = s_valid && s_ready;
      out_acc   = m_valid && m_ready;
      was_first = m_first;
      if (in_acc) begin
         if (m_first) begin m_sh = cfg_shift; m_relu = cfg_relu; end
         model(s_data, o, c);
         e.dat = o; e.last = s_last; e.user = s_user; e.clip = c; e.cyc = cyc;
         q.push_back(e);
         m_first = s_last;
      end
      if (cfg_wr_en && !m_busy && !(in_acc && was_first) && cfg_wr_addr < ROWS)
         bias_m[cfg_wr_addr] = longint'($signed(cfg_wr_data));
      if (out_acc) begin
         n_vec++;
         assert (q.size() != 0) else begin
            n_err++;
            $error("FAIL spurious_out: got beat %0h, want none", m_data);
         end
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("m_data", m_data, e.dat);
            chk("m_last", m_last, e.last);
            chk("m_user", m_user, e.user);
            last_out = m_data;
            last_lat = cyc - e.cyc;
            if (e.clip && m_sat < 16'hFFFF) m_sat++;
            if (e.last) m_busy = 0;
         end
      end
      if (in_acc && was_first) m_busy = 1;
      cyc++;
      acc = in_acc;
      @(posedge aclk); #1;
      m_ready = ($urandom_range(99) < rdy_pct);
   endtask

   function automatic logic [ROWS*WI-1:0] gen(input int mode, input int i, input int v);
      logic [ROWS*WI-1:0] d;
      int rv;
      d = '0;
      for (int r = 0; r < ROWS; r++) begin
         rv = int'($urandom_range(131071)) - 65536;
         case (mode)
            0:       d[r*WI +: WI] = WI'(rv);
            1:       d[r*WI +: WI] = WI'(i);
            default: if (r == 0) d[r*WI +: WI] = WI'(v);
         endcase
      end
      return d;
   endfunction

   task automatic send_beat(input logic [ROWS*WI-1:0] d, input logic last, inout int cycles);
      bit acc;
      int guard;
      s_valid = 1; s_data = d; s_last = last; s_user = TU'($urandom);
      acc = 0; guard = 0;
      while (!acc && guard < 1000) begin step(acc); guard++; cycles++; end
      n_vec++;
      assert (acc) else begin
         n_err++;
         $error("FAIL accept_timeout: got no s_ready in %0d cycles, want acceptance", guard);
      end
   endtask

   task automatic send_pkt(input int n, input int mode, input int v, output int cycles);
      cycles = 0;
      for (int i = 0; i < n; i++) send_beat(gen(mode, i, v), (i == n - 1), cycles);
      s_valid = 0; s_last = 0;
   endtask

   task automatic drain();
      bit acc;
      int guard;
      guard = 0;
      while ((q.size() != 0 || m_valid) && guard < 500) begin step(acc); guard++; end
      n_vec++;
      assert (q.size() == 0) else begin
         n_err++;
         $error("FAIL drain_timeout: got %0d beats outstanding, want 0", q.size());
      end
   endtask

   task automatic cfg_write(input int a, input longint v);
      bit acc;
      cfg_wr_en = 1; cfg_wr_addr = AW'(a); cfg_wr_data = WI'(v);
      step(acc);
      cfg_wr_en = 0;
   endtask

   task automatic do_reset();
      aresetn = 0; s_valid = 0; s_last = 0; cfg_wr_en = 0;
      repeat (2) @(negedge aclk);
      chk("rst_s_ready", s_ready, 1);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_last", m_last, 0);
      chk("rst_cfg_ready", cfg_ready, 1);
      chk("rst_sat_count", sat_count, 0);
      q.delete();
      for (int r = 0; r < ROWS; r++) bias_m[r] = 0;
      m_first = 1; m_busy = 0; m_sat = 0; m_sh = 0; m_relu = 0;
      aresetn = 1;
      @(posedge aclk); #1;
   endtask

   initial begin
      bit acc;
      n_vec = 0; n_err = 0; cyc = 0; rdy_pct = 100;
      do_reset();

      // basic: (21 + 10 + 2) >> 2 = 8, handshake-to-handshake latency 3
      cfg_shift = 2; cfg_relu = 0;
      cfg_write(0, 10);
      send_pkt(1, 2, 21, ncy); drain();
      chk("t1_data", last_out[7:0], 8'd8);
      chk("t1_latency", last_lat, 3);

      // clipping, with and without ReLU
      cfg_shift = 0;
      send_pkt(1, 2, -1000, ncy); drain();
      chk("t2_clip_data", last_out[7:0], 8'h80);
      chk("t2_clip_sat", sat_count, 1);
      cfg_relu = 1;
      send_pkt(1, 2, -1000, ncy); drain();
      chk("t2_relu_data", last_out[7:0], 8'h00);
      chk("t2_relu_sat", sat_count, 1);

      // backpressure: 20 counting beats under random m_ready
      cfg_relu = 0;
      cfg_write(0, 0);
      rdy_pct = 50;
      send_pkt(20, 1, 0, ncy); drain();
      chk("t3_last_beat", last_out, {ROWS{8'd19}});

      // config guard: mid-packet write ignored, post-packet write applied
      rdy_pct = 100; m_ready = 1;
      ncy = 0;
      send_beat('0, 0, ncy); s_valid = 0;
      chk("t4_cfg_ready_busy", cfg_ready, 0);
      cfg_write(1, 50);
      send_beat('0, 1, ncy); s_valid = 0;
      drain();
      chk("t4_ignored", last_out[15:8], 8'd0);
      chk("t4_cfg_ready_idle", cfg_ready, 1);
      cfg_write(1, 50);
      send_pkt(1, 2, 0, ncy); drain();
      chk("t4_applied", last_out[15:8], 8'd50);
      // write coinciding with a packet's first beat is dropped
      cfg_wr_en = 1; cfg_wr_addr = 2; cfg_wr_data = 77;
      send_beat('0, 0, ncy);
      cfg_wr_en = 0;
      send_beat('0, 1, ncy); s_valid = 0;
      drain();
      chk("t4_first_beat_write", last_out[23:16], 8'd0);
      cfg_write(1, 0);

      // randomized packets, config and bias writes (some land while busy)
      rdy_pct = 60;
      for (int p = 0; p < 10; p++) begin
         cfg_shift = 5'($urandom_range(12));
         cfg_relu  = 1'($urandom_range(1));
         if ($urandom_range(1) == 1)
            cfg_write(int'($urandom_range(ROWS - 1)), longint'(int'($urandom_range(4000)) - 2000));
         send_pkt(1 + int'($urandom_range(7)), 0, 0, ncy);
      end
      drain();

      // reset with two beats in flight
      cfg_write(0, 33);
      cfg_shift = 0; cfg_relu = 0;
      rdy_pct = 0; m_ready = 0;
      ncy = 0;
      send_beat(gen(0, 0, 0), 0, ncy);
      send_beat(gen(0, 1, 0), 0, ncy);
      s_valid = 0;
      do_reset();
      rdy_pct = 100; m_ready = 1;
      for (int k = 0; k < 6; k++) begin
         step(acc);
         chk("t5_no_valid", m_valid, 0);
      end
      send_pkt(1, 2, 5, ncy); drain();
      chk("t5_bias_cleared", last_out[7:0], 8'd5);

      // counter limit, also full-rate acceptance
      send_pkt(65540, 2, 1000, ncy);
      chk("t6_throughput", ncy, 65540);
      drain();
      chk("t6_sat_hold", sat_count, 16'hFFFF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
